// File: rtl/acc_arbiter.sv
// Two-port round-robin arbiter in front of the CPU accumulator: registered grants,
// burst-limited ownership, and a combinational write mux onto the accumulator en/in.

module acc_arbiter_port #(
  parameter int WIDTH = 8
) (
  input  logic             gnt,
  input  logic             wr,
  input  logic [WIDTH-1:0] data,
  output logic             wen,
  output logic [WIDTH-1:0] wdata
);
  // Zeroing ungranted data lets the top OR-merge ports without a priority mux.
  assign wen   = gnt & wr;
  assign wdata = wen ? data : '0;
endmodule

module acc_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             wr0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             wr1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             acc_en,
  output logic [WIDTH-1:0] acc_in
);
  localparam int NUM_PORTS = 2;
  localparam int CNT_W     = 4;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                               state, state_nxt;
  logic                                 last, last_nxt;
  logic [CNT_W-1:0]                     cnt, cnt_nxt;
  logic [NUM_PORTS-1:0]                 gnt_q;
  logic [NUM_PORTS-1:0]                 wr, wen;
  logic [NUM_PORTS-1:0][WIDTH-1:0]      data, wdata;

  assign wr   = {wr1, wr0};
  assign data = {data1, data0};
  assign gnt0 = gnt_q[0];
  assign gnt1 = gnt_q[1];

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)                                  state_nxt = req1 ? OWN1 : IDLE;
        else if (wr0 && req1 && cnt == BURST_LAST)  state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)                                  state_nxt = req0 ? OWN0 : IDLE;
        else if (wr1 && req0 && cnt == BURST_LAST)  state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase

    // Burst count only advances under contention, so a lone owner is never evicted.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state == OWN0)      last_nxt = 1'b0;
      else if (state == OWN1) last_nxt = 1'b1;
    end else if (state == OWN0 && wr0 && req1) begin
      cnt_nxt = cnt + 1'b1;
    end else if (state == OWN1 && wr1 && req0) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      gnt_q <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      gnt_q <= {state_nxt == OWN1, state_nxt == OWN0};
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      acc_arbiter_port #(.WIDTH(WIDTH)) u_port (
        .gnt   (gnt_q[p]),
        .wr    (wr[p]),
        .data  (data[p]),
        .wen   (wen[p]),
        .wdata (wdata[p])
      );
    end
  endgenerate

  // Grants are one-hot, so an OR merge is the steering mux.
  assign acc_en = |wen;
  assign acc_in = wdata[0] | wdata[1];

endmodule

// File: doc/acc_arbiter.md
# acc_arbiter

Two-port round-robin arbiter that shares the CPU accumulator register between two writers. Port 0 is the ALU writeback path and port 1 is the I/O / debug load path. The block registers a grant per requester and steers the granted requester's write strobe and data onto the accumulator's `en`/`in` inputs. A burst limit forces rotation, so neither requester can starve the other. It sits between the requesters and the accumulator; readers take the accumulator output and zero flag directly.

## Interface

- `WIDTH`, default 8: accumulator data width.
- `MAX_BURST`, default 4: maximum accepted writes per grant while the other port is requesting. Legal range is 1..15.

- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req0`, in, 1: port 0 requests ownership.
- `wr0`, in, 1: port 0 write strobe. Valid only while `gnt0` is high.
- `data0`, in, WIDTH: port 0 write data.
- `gnt0`, out, 1: registered grant to port 0.
- `req1`, in, 1: port 1 request.
- `wr1`, in, 1: port 1 write strobe.
- `data1`, in, WIDTH: port 1 write data.
- `gnt1`, out, 1: registered grant to port 1.
- `acc_en`, out, 1: drives the accumulator's enable.
- `acc_in`, out, WIDTH: drives the accumulator's data input.

## Operation

- **Reset.** One clock; reset is asynchronous and active-low on `rst_n`. Reset forces:
  - state = IDLE, `gnt0` = `gnt1` = 0;
  - `last` = 1, so port 0 wins the first tie;
  - burst count `cnt` = 0.
- **Outputs while in reset.** `acc_en` = 0 and `acc_in` = 0 immediately on assertion of reset, including when it lands mid-burst. The accumulator keeps its value because its enable is low.
- **States.**
  - IDLE: no grants.
  - OWN0: `gnt0` = 1.
  - OWN1: `gnt1` = 1.
  - At most one grant is ever high.
- **Datapath, combinational from registered state.**
  - `acc_en` = (`gnt0` & `wr0`) | (`gnt1` & `wr1`).
  - `acc_in` = `data0` when `gnt0` & `wr0`; `data1` when `gnt1` & `wr1`; otherwise all zeros.
  - A `wr` strobe without its grant is ignored: no write, no error.
- **IDLE transitions.**
  - Only `req0` high → OWN0. Only `req1` high → OWN1.
  - Both high → grant the port ≠ `last`.
  - Neither high → stay in IDLE.
- **OWNx transitions**, evaluated at each edge; x is the owner, y the other port.
  - `reqx` low: go to OWNy if `reqy` is high, else IDLE. A write in this same cycle still completes, because `gnt` is registered.
  - `reqx` high, a write this cycle, `cnt`+1 == `MAX_BURST`, and `reqy` high: forced rotation to OWNy.
  - Otherwise stay in OWNx.
- **Burst counter.**
  - Increments on each accepted write while `reqy` is high.
  - Holds while `reqy` is low, so an uncontended owner is never forced out.
  - Clears to 0 on every state change.
  - Width ≥ 4 bits; never exceeds `MAX_BURST`.
- **`last`.** Updated to the owner's index whenever a grant ends, whether by release or rotation.
- **Direct handover.** OWNx → OWNy is gap-free: `gnt`x falls and `gnt`y rises on the same edge, with no IDLE cycle between them.

## Timing

- **Grant latency.** A request sampled at edge k makes `gnt` high after edge k (one cycle). The earliest write lands in the accumulator at edge k+1.
- **Write path.** Combinational from `gnt`/`wr`/`data` to `acc_en`/`acc_in`, so the accumulator captures on the same edge the write is presented.
- **Release latency.** `gnt` falls one edge after `req` is sampled low.
- **Throughput.** A granted port can write every cycle.

## Test plan

- **Reset mid-burst.** Port 0 owns and `wr0` = 1 with `data0` = 8'h5A. Assert `rst_n` = 0 between edges → `gnt0`, `acc_en` = 0 and `acc_in` = 8'h00 immediately. After release, a `req1` pulse gets `gnt1` one cycle later.
- **Simultaneous first request.** From reset, `req0` = `req1` = 1 at the same edge → `gnt0` = 1. Port 0 writes 8'h11, then drops `req0` → next edge `gnt1` = 1 with no idle gap. Port 1 writes 8'h22 and the accumulator reads 8'h22.
- **Forced rotation.** `MAX_BURST` = 4. Port 0 writes 8'h01..8'h04 on consecutive cycles while `req1` is held → `gnt0` falls after the 4th write edge and `gnt1` rises on that same edge. A 5th `wr0` = 1 with 8'h05 is ignored and the accumulator holds 8'h04.
- **Uncontended owner.** Port 1 alone writes 10 consecutive values with `req0` = 0 → `gnt1` stays high throughout and all 10 values reach the accumulator. Raising `req0` afterwards forces rotation after 4 further writes.
- **Ungranted strobe.** In IDLE, `wr1` = 1 with `data1` = 8'hFF → `acc_en` = 0 and `acc_in` = 8'h00; the accumulator is unchanged.
- **Round-robin fairness.** Both requesters are held permanently with writes every cycle → grants alternate in 4-write bursts: 0,1,0,1…; `gnt0` and `gnt1` are never high together.
